// File: rtl/conv_test_pkg.sv
// Shared types and size helpers for the convolution-engine stream self-test.
package conv_test_pkg;

  localparam int unsigned PIX_W_DEF = 8;
  localparam int unsigned ACC_W_DEF = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FSTART,
    S_FEED,
    S_DRAIN,
    S_CHECK,
    S_DONE
  } state_t;

  typedef logic signed [PIX_W_DEF-1:0] pixel_t;
  typedef logic signed [ACC_W_DEF-1:0] result_t;

  // Results produced per frame by a valid, stride-1 convolution.
  function automatic int unsigned out_count(input int unsigned mapsize,
                                            input int unsigned ksize,
                                            input int unsigned nch);
    return (mapsize - ksize + 1) * (mapsize - ksize + 1) * nch;
  endfunction

  // Index width for n entries, never narrower than one bit.
  function automatic int unsigned addr_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_stream_fifo2.sv
// Two-entry valid/ready FIFO; head data holds still until popped.
module conv_stream_fifo2 #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] data,
  output logic [1:0]   occ
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   cnt;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop && (cnt != 2'd0);
  assign do_push = push && ((cnt != 2'd2) || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else if (clr) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + 2'(do_push) - 2'(do_pop);
    end
  end

  assign valid = (cnt != 2'd0);
  assign data  = mem[rd_ptr];
  assign occ   = cnt;

endmodule

// File: rtl/conv_stream_selftest.sv
// Self-test controller: streams an image ROM into a convolution engine and
// checks each result against a golden ROM, over a programmable frame count.
module conv_stream_selftest
  import conv_test_pkg::*;
#(
  parameter int unsigned PIX_W       = 8,
  parameter int unsigned ACC_W       = 32,
  parameter int unsigned MAPSIZE     = 32,
  parameter int unsigned KSIZE       = 5,
  parameter int unsigned NUM_CH      = 1,
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter int unsigned ERR_W       = 16,
  localparam int unsigned OUT_COUNT  = out_count(MAPSIZE, KSIZE, NUM_CH),
  localparam int unsigned IMG_AW     = addr_w(MAPSIZE * MAPSIZE),
  localparam int unsigned GOLD_AW    = addr_w(OUT_COUNT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [7:0]         num_frames,
  output logic [IMG_AW-1:0]  img_addr,
  input  logic [PIX_W-1:0]   img_data,
  output logic [GOLD_AW-1:0] gold_addr,
  input  logic [ACC_W-1:0]   gold_data,
  output logic               dut_start,
  output logic               dut_valid,
  output logic [PIX_W-1:0]   dut_pixel,
  input  logic               dut_ready,
  input  logic               dut_wr_en,
  input  logic [GOLD_AW-1:0] dut_wr_addr,
  input  logic [ACC_W-1:0]   dut_wr_data,
  input  logic               dut_done,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               timeout,
  output logic [ERR_W-1:0]   err_count,
  output logic [GOLD_AW-1:0] first_err_addr,
  output logic [7:0]         frame_cnt
);

  localparam int unsigned IMG_N = MAPSIZE * MAPSIZE;
  localparam int unsigned PTR_W = IMG_AW + 1;
  localparam int unsigned RES_W = GOLD_AW + 1;
  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYC + 1);

  state_t             state;
  state_t             state_nxt;
  logic [PTR_W-1:0]   ptr;
  logic               rd_pend;
  logic               rd_issue;
  logic [1:0]         fifo_occ;
  logic               fifo_clr;
  logic               pop;
  logic [7:0]         frames_tot;
  logic [RES_W-1:0]   res_cnt;
  logic [WD_W-1:0]    wd_cnt;
  logic               wd_fire;
  logic               done_seen;
  logic               start_ok;
  logic               chk_en;
  logic               s1_valid;
  logic               s1_oob;
  logic [GOLD_AW-1:0] s1_addr;
  logic [ACC_W-1:0]   s1_data;
  logic               err_inc;
  logic [GOLD_AW-1:0] err_addr;
  logic [ERR_W-1:0]   err_nxt;
  logic               to_nxt;

  assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE));
  assign chk_en    = (state == S_FEED) || (state == S_DRAIN) || (state == S_CHECK);
  assign wd_fire   = ((state == S_FEED) || (state == S_DRAIN)) && (wd_cnt >= WD_W'(TIMEOUT_CYC));
  assign pop       = dut_valid && dut_ready;
  assign fifo_clr  = (state_nxt != S_FEED);
  assign img_addr  = ptr[IMG_AW-1:0];
  assign gold_addr = dut_wr_addr;
  assign to_nxt    = timeout || wd_fire;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state, ROM read issue and error detection.
  always_comb begin
    state_nxt = state;
    rd_issue  = 1'b0;
    err_inc   = 1'b0;
    err_addr  = '0;
    err_nxt   = err_count;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_FSTART;
      S_FSTART:       state_nxt = S_FEED;
      S_FEED: begin
        rd_issue = (({1'b0, fifo_occ} + {2'b0, rd_pend}) < 3'd2) && (ptr < PTR_W'(IMG_N));
        if (wd_fire) state_nxt = S_DONE;
        else if ((ptr == PTR_W'(IMG_N)) && !rd_pend && (fifo_occ == 2'd0)) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (wd_fire) state_nxt = S_DONE;
        else if (dut_done || done_seen) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (!s1_valid) begin
          if (res_cnt != RES_W'(OUT_COUNT)) begin
            err_inc  = 1'b1;
            err_addr = GOLD_AW'(res_cnt);
          end
          state_nxt = (({1'b0, frame_cnt} + 9'd1) >= {1'b0, frames_tot}) ? S_DONE : S_FSTART;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // Stage-2 compare; a stale result landing in IDLE/DONE is dropped.
    if (s1_valid && (state != S_IDLE) && (state != S_DONE) &&
        (s1_oob || (gold_data != s1_data))) begin
      err_inc  = 1'b1;
      err_addr = s1_addr;
    end
    if (err_inc && (err_count != '1)) err_nxt = err_count + ERR_W'(1);
  end

  conv_stream_fifo2 #(.W(PIX_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (fifo_clr),
    .push      (rd_pend && (state == S_FEED)),
    .push_data (img_data),
    .pop       (pop),
    .valid     (dut_valid),
    .data      (dut_pixel),
    .occ       (fifo_occ)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      dut_start      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      frame_cnt      <= '0;
      frames_tot     <= '0;
      ptr            <= '0;
      rd_pend        <= 1'b0;
      res_cnt        <= '0;
      wd_cnt         <= '0;
      done_seen      <= 1'b0;
      s1_valid       <= 1'b0;
      s1_oob         <= 1'b0;
      s1_addr        <= '0;
      s1_data        <= '0;
    end else begin
      dut_start <= (state_nxt == S_FSTART);
      busy      <= (state_nxt != S_IDLE) && (state_nxt != S_DONE);
      done      <= (state_nxt == S_DONE);
      pass      <= (state_nxt == S_DONE) && (err_nxt == '0) && !to_nxt;
      rd_pend   <= rd_issue;

      s1_valid <= chk_en && dut_wr_en;
      s1_oob   <= (32'(dut_wr_addr) >= 32'(OUT_COUNT));
      s1_addr  <= dut_wr_addr;
      s1_data  <= dut_wr_data;

      if (state == S_FSTART)  ptr <= '0;
      else if (rd_issue)      ptr <= ptr + PTR_W'(1);

      if (state == S_FSTART)                             res_cnt <= '0;
      else if (chk_en && dut_wr_en && (res_cnt != '1))   res_cnt <= res_cnt + RES_W'(1);

      // Watchdog restarts on any sign of life from the engine.
      if ((state == S_FSTART) || pop || dut_wr_en) wd_cnt <= '0;
      else if (((state == S_FEED) || (state == S_DRAIN)) && (wd_cnt < WD_W'(TIMEOUT_CYC)))
        wd_cnt <= wd_cnt + WD_W'(1);

      if (state == S_FSTART)                                          done_seen <= 1'b0;
      else if (((state == S_FEED) || (state == S_DRAIN)) && dut_done) done_seen <= 1'b1;

      if (start_ok) begin
        frames_tot     <= (num_frames == 8'd0) ? 8'd1 : num_frames;
        err_count      <= '0;
        first_err_addr <= '0;
        timeout        <= 1'b0;
        frame_cnt      <= '0;
      end else begin
        err_count <= err_nxt;
        if (err_inc && (err_count == '0)) first_err_addr <= err_addr;
        if (wd_fire) timeout <= 1'b1;
        if ((state == S_CHECK) && !s1_valid) frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

endmodule
